bus2st_pingpong: RTL and testbench

Parametrised, double-buffered successor to the single-packet bus-to-Avalon-ST converter, single clock domain (clk_bus). It accepts wide memory-bus words from the NLB AFU read path, stores one turbo packet per bank in two ping-pong banks, and unpacks each packet LSB-first into narrow Avalon-ST beats for the turbo decoder. It honours st_ready per beat, so the next packet can be written while the current one drains.

---
 rtl/bus2st_pkg.sv | 23 ++
 rtl/bus2st_pingpong_if.sv | 33 +++
 rtl/bus2st_dpram.sv | 27 ++
 rtl/bus2st_pingpong.sv | 210 +++++++++++++++++++++
 tb/tb_bus2st_pingpong.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus2st_pkg.sv
// Shared types and width helpers for the bus-to-Avalon-ST ping-pong converter.
// Optional feature macro used by the top level: BUS2ST_PKT_CNT_EN.
package bus2st_pkg;

    // Reader FSM states, exposed on the top level's debug port.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } rd_state_t;

    // Width of a counter that walks 0..n-1.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Width of a counter that must also hold the value n itself.
    function automatic int cnt_inc_w(input int n);
        return (n <= 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/bus2st_pingpong_if.sv
// Bus-write and Avalon-ST signals of the ping-pong converter.
//
// Handshakes: the bus side writes a word on a cycle where bus_en=1 and
// bus_ready=1 (bus_en while bus_ready=0 is dropped and flagged). The ST side
// transfers a beat on a cycle where st_valid=1 and st_ready=1 (readyLatency 0);
// while st_ready=0 the source holds st_data/st_valid/st_sop/st_eop stable, and
// st_valid stays high from sop to eop.
interface bus2st_pingpong_if #(
    parameter int BUS_W = 534,
    parameter int ST_W  = 12
);
    logic [BUS_W-1:0] bus_data;
    logic             bus_en;
    logic             bus_ready;
    logic             st_ready;
    logic [ST_W-1:0]  st_data;
    logic             st_valid;
    logic             st_sop;
    logic             st_eop;
    logic             st_error;

    // Converter side.
    modport slave (
        input  bus_data, bus_en, st_ready,
        output bus_ready, st_data, st_valid, st_sop, st_eop, st_error
    );

    // Producer of bus words / consumer of ST beats.
    modport master (
        output bus_data, bus_en, st_ready,
        input  bus_ready, st_data, st_valid, st_sop, st_eop, st_error
    );
endinterface

// File: rtl/bus2st_dpram.sv
// Simple dual-port packet store: one write port, one read port with a
// registered read (data appears the cycle after rd_en), single clock.
module bus2st_dpram #(
    parameter int DEPTH = 50,
    parameter int WIDTH = 504,
    parameter int AW    = 6
) (
    input  logic             clk_bus,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk_bus) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Registered read port; rd_data holds its value until the next rd_en.
    always_ff @(posedge clk_bus) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/bus2st_pingpong.sv
// Double-buffered bus-to-Avalon-ST converter. Two packet banks alternate:
// the writer fills one while the reader unpacks the other LSB-first into
// ST_W-bit beats. Optional macro BUS2ST_PKT_CNT_EN adds a 16-bit packet counter.
module bus2st_pingpong
    import bus2st_pkg::*;
#(
    parameter int BUS_W       = 534,
    parameter int ST_W        = 12,
    parameter int ST_PER_BUS  = 42,
    parameter int BUS_PER_PKT = 25,
    parameter int ST_PER_PKT  = 1028
) (
    input  logic                    clk_bus,
    input  logic                    rst_n,
    bus2st_pingpong_if.slave        bus,
    output logic                    pkt_done,
    output logic                    ovf_err,
    output rd_state_t               rd_state_dbg
`ifdef BUS2ST_PKT_CNT_EN
    ,
    output logic [15:0]             pkt_cnt
`endif
);
    localparam int RAM_W = ST_PER_BUS * ST_W;
    localparam int WA_W  = cnt_w(BUS_PER_PKT);
    localparam int SL_W  = cnt_w(ST_PER_BUS);
    localparam int BC_W  = cnt_inc_w(ST_PER_PKT);
    localparam int AW    = cnt_w(2 * BUS_PER_PKT);

    // ---------------- writer and bank flags ----------------
    logic [1:0]      full_q;
    logic [1:0]      full_seen;
    logic            wr_bank;
    logic            rd_bank;
    logic [WA_W-1:0] wr_addr;
    logic            wr_fire;
    logic            wr_last;
    logic            free_bank;
    logic [AW-1:0]   wr_ram_addr;

    assign bus.bus_ready = !full_q[wr_bank];
    assign wr_fire       = bus.bus_en && !full_q[wr_bank];
    assign wr_last       = wr_fire && (wr_addr == WA_W'(BUS_PER_PKT - 1));
    // Bank b occupies the linear range [b*BUS_PER_PKT, (b+1)*BUS_PER_PKT).
    assign wr_ram_addr   = (wr_bank ? AW'(BUS_PER_PKT) : '0) + AW'(wr_addr);

    // Word address, bank pointer and sticky overflow flag of the writer.
    always_ff @(posedge clk_bus) begin
        if (!rst_n) begin
            wr_addr <= '0;
            wr_bank <= 1'b0;
            ovf_err <= 1'b0;
        end else begin
            if (bus.bus_en && full_q[wr_bank]) ovf_err <= 1'b1;
            if (wr_fire) begin
                if (wr_last) begin
                    wr_addr <= '0;
                    wr_bank <= !wr_bank;
                end else begin
                    wr_addr <= wr_addr + 1'b1;
                end
            end
        end
    end

    // Full flags: writer sets the bank it completes, reader clears the bank it frees.
    // full_seen is the reader's one-cycle-delayed view, which fixes the
    // last-write-to-sop latency at three edges.
    always_ff @(posedge clk_bus) begin
        if (!rst_n) begin
            full_q    <= '0;
            full_seen <= '0;
            rd_bank   <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (wr_last && (wr_bank == 1'(b))) full_q[b] <= 1'b1;
                else if (free_bank && (rd_bank == 1'(b))) full_q[b] <= 1'b0;
            end
            full_seen <= full_q;
            if (free_bank) rd_bank <= !rd_bank;
        end
    end

    // ---------------- packet store ----------------
    logic             rd_en;
    logic [WA_W-1:0]  rd_word;
    logic [AW-1:0]    rd_ram_addr;
    logic [RAM_W-1:0] rd_data;

    assign rd_ram_addr = (rd_bank ? AW'(BUS_PER_PKT) : '0) + AW'(rd_word);

    bus2st_dpram #(
        .DEPTH (2 * BUS_PER_PKT),
        .WIDTH (RAM_W),
        .AW    (AW)
    ) u_ram (
        .clk_bus (clk_bus),
        .wr_en   (wr_fire),
        .wr_addr (wr_ram_addr),
        .wr_data (bus.bus_data[RAM_W-1:0]),
        .rd_en   (rd_en),
        .rd_addr (rd_ram_addr),
        .rd_data (rd_data)
    );

    // Bits above the packed slices carry nothing for the decoder.
    generate
        if (BUS_W > RAM_W) begin : g_pad
            logic unused_pad;
            assign unused_pad = ^bus.bus_data[BUS_W-1:RAM_W];
        end
    endgenerate

    // ---------------- reader FSM ----------------
    rd_state_t        state_q;
    rd_state_t        state_d;
    logic [RAM_W-1:0] shift_q;
    logic [SL_W-1:0]  slice_q;
    logic [BC_W-1:0]  beat_q;
    logic             accept;
    logic             slice_last;
    logic             beat_last;

    assign accept     = (state_q == STREAM) && bus.st_ready;
    assign slice_last = (slice_q == SL_W'(ST_PER_BUS - 1));
    assign beat_last  = (beat_q == BC_W'(ST_PER_PKT - 1));

    // Reader state register.
    always_ff @(posedge clk_bus) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state plus RAM read requests. IDLE fetches word 0 and LOAD fetches
    // word 1, so the prefetch register (rd_data) is always one word ahead.
    always_comb begin
        state_d   = state_q;
        rd_en     = 1'b0;
        free_bank = 1'b0;
        case (state_q)
            IDLE: begin
                if (full_seen[rd_bank]) begin
                    rd_en   = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                rd_en   = 1'b1;
                state_d = STREAM;
            end
            STREAM: begin
                if (accept) begin
                    if (beat_last)       state_d = DONE;
                    else if (slice_last) rd_en   = 1'b1;
                end
            end
            DONE: begin
                free_bank = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Shift register, slice/beat counters and read word pointer.
    always_ff @(posedge clk_bus) begin
        if (!rst_n) begin
            shift_q <= '0;
            slice_q <= '0;
            beat_q  <= '0;
            rd_word <= '0;
        end else begin
            if (rd_en) begin
                rd_word <= (rd_word == WA_W'(BUS_PER_PKT - 1)) ? '0 : rd_word + 1'b1;
            end
            if (state_q == DONE) rd_word <= '0;
            if (state_q == LOAD) begin
                shift_q <= rd_data;
                slice_q <= '0;
                beat_q  <= '0;
            end else if (accept) begin
                beat_q <= beat_q + 1'b1;
                if (slice_last) begin
                    shift_q <= rd_data;
                    slice_q <= '0;
                end else begin
                    shift_q <= shift_q >> ST_W;
                    slice_q <= slice_q + 1'b1;
                end
            end
        end
    end

    // ---------------- output stage ----------------
    assign bus.st_data  = shift_q[ST_W-1:0];
    assign bus.st_valid = (state_q == STREAM);
    assign bus.st_sop   = (state_q == STREAM) && (beat_q == '0);
    assign bus.st_eop   = (state_q == STREAM) && beat_last;
    assign bus.st_error = 1'b0;
    assign pkt_done     = (state_q == DONE);
    assign rd_state_dbg = state_q;

`ifdef BUS2ST_PKT_CNT_EN
    // Count freed banks; wraps naturally at 16'hFFFF.
    always_ff @(posedge clk_bus) begin
        if (!rst_n)        pkt_cnt <= '0;
        else if (pkt_done) pkt_cnt <= pkt_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_bus2st_pingpong.sv
// Self-checking bench for bus2st_pingpong (table of packet runs plus
// hand-written ping-pong, overflow and mid-stream reset sequences).
module tb_bus2st_pingpong;
    import bus2st_pkg::*;

    localparam int BUS_W       = 534;
    localparam int ST_W        = 12;
    localparam int ST_PER_BUS  = 42;
    localparam int BUS_PER_PKT = 25;
    localparam int ST_PER_PKT  = 1028;
    localparam int RAM_W       = ST_PER_BUS * ST_W;
    localparam int EW          = ST_W + 2;

    // ---------------- clock / reset ----------------
    logic      clk_bus = 1'b0;
    logic      rst_n   = 1'b0;
    logic      pkt_done;
    logic      ovf_err;
    rd_state_t rd_state_dbg;
`ifdef BUS2ST_PKT_CNT_EN
    logic [15:0] pkt_cnt;
`endif

    always #5 clk_bus = ~clk_bus;

    bus2st_pingpong_if #(.BUS_W(BUS_W), .ST_W(ST_W)) bus_if ();

    bus2st_pingpong #(
        .BUS_W       (BUS_W),
        .ST_W        (ST_W),
        .ST_PER_BUS  (ST_PER_BUS),
        .BUS_PER_PKT (BUS_PER_PKT),
        .ST_PER_PKT  (ST_PER_PKT)
    ) dut (
        .clk_bus      (clk_bus),
        .rst_n        (rst_n),
        .bus          (bus_if),
        .pkt_done     (pkt_done),
        .ovf_err      (ovf_err),
        .rd_state_dbg (rd_state_dbg)
`ifdef BUS2ST_PKT_CNT_EN
        ,
        .pkt_cnt      (pkt_cnt)
`endif
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [EW-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- st_ready driver ----------------
    int ready_mode = 0;  // 0: always ready, 1: random 50%, 2: never ready

    always @(posedge clk_bus) begin
        #1;
        case (ready_mode)
            0:       bus_if.st_ready = 1'b1;
            1:       bus_if.st_ready = 1'($urandom_range(0, 1));
            default: bus_if.st_ready = 1'b0;
        endcase
    end

    // ---------------- output monitor ----------------
    int              beats_seen = 0;
    int              done_seen  = 0;
    int              idle_run   = 0;
    int              last_gap   = -1;
    bit              prev_stall = 1'b0;
    bit              prev_eop_xfer = 1'b0;
    logic [ST_W+2:0] prev_out;
    logic [EW-1:0]   mon_e;

    always @(negedge clk_bus) begin
        if (!rst_n) begin
            prev_stall    = 1'b0;
            prev_eop_xfer = 1'b0;
            idle_run      = 0;
        end else begin
            check("pkt_done_timing", pkt_done, prev_eop_xfer);
            if (pkt_done) done_seen++;
            if (prev_stall)
                check("hold_while_stalled",
                      {bus_if.st_data, bus_if.st_valid, bus_if.st_sop, bus_if.st_eop}, prev_out);
            if (bus_if.st_valid && bus_if.st_sop && idle_run > 0) last_gap = idle_run;
            if (bus_if.st_valid) idle_run = 0;
            else                 idle_run++;
            if (bus_if.st_valid && bus_if.st_ready) begin
                if (exp_q.size() == 0) begin
                    check("beat_queue_depth", exp_q.size(), 1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("beat_data_sop_eop", {bus_if.st_data, bus_if.st_sop, bus_if.st_eop}, mon_e);
                end
                check("st_error", bus_if.st_error, 0);
                beats_seen++;
            end
            prev_eop_xfer = bus_if.st_valid && bus_if.st_ready && bus_if.st_eop;
            prev_stall    = bus_if.st_valid && !bus_if.st_ready;
            prev_out      = {bus_if.st_data, bus_if.st_valid, bus_if.st_sop, bus_if.st_eop};
        end
    end

    // ---------------- driver helpers ----------------
    function automatic logic [BUS_W-1:0] make_word(input int base, input int w);
        logic [BUS_W-1:0] d;
        d = '0;
        for (int k = 0; k < ST_PER_BUS; k++) d[k*ST_W +: ST_W] = ST_W'(base + w * ST_PER_BUS + k);
        for (int b = RAM_W; b < BUS_W; b++) d[b] = 1'($urandom_range(0, 1));
        return d;
    endfunction

    task automatic push_pkt(input int base);
        for (int i = 0; i < ST_PER_PKT; i++)
            exp_q.push_back({ST_W'(base + i), 1'(i == 0), 1'(i == ST_PER_PKT - 1)});
    endtask

    // Writes one packet back-to-back; call and return aligned at posedge+1.
    task automatic send_pkt(input int base);
        push_pkt(base);
        for (int w = 0; w < BUS_PER_PKT; w++) begin
            bus_if.bus_data = make_word(base, w);
            bus_if.bus_en   = 1'b1;
            @(negedge clk_bus);
            check("bus_ready_on_write", bus_if.bus_ready, 1);
            @(posedge clk_bus);
            #1;
        end
        bus_if.bus_en = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk_bus);
            n++;
        end
        if (n >= budget) check("drain_timeout", exp_q.size(), 0);
        repeat (4) @(negedge clk_bus);
        @(posedge clk_bus);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int   base;
        int   rmode;
        bit   chk_lat;
        int   exp_lat;
        int   exp_beats;
        int   exp_done;
        logic exp_ovf;
        logic exp_ready;
    } vec_t;

    vec_t vecs[4];
    int   b0, d0, lat, n;
    bit   found;

    initial begin
        bus_if.bus_en   = 1'b0;
        bus_if.bus_data = '0;
        vecs[0] = '{base: 0,    rmode: 0, chk_lat: 1, exp_lat: 3, exp_beats: ST_PER_PKT, exp_done: 1, exp_ovf: 1'b0, exp_ready: 1'b1};
        vecs[1] = '{base: 100,  rmode: 1, chk_lat: 0, exp_lat: 3, exp_beats: ST_PER_PKT, exp_done: 1, exp_ovf: 1'b0, exp_ready: 1'b1};
        vecs[2] = '{base: 3500, rmode: 1, chk_lat: 1, exp_lat: 3, exp_beats: ST_PER_PKT, exp_done: 1, exp_ovf: 1'b0, exp_ready: 1'b1};
        vecs[3] = '{base: 7,    rmode: 0, chk_lat: 0, exp_lat: 3, exp_beats: ST_PER_PKT, exp_done: 1, exp_ovf: 1'b0, exp_ready: 1'b1};

        // Reset state.
        repeat (3) @(posedge clk_bus);
        @(negedge clk_bus);
        check("rst_st_valid", bus_if.st_valid, 0);
        check("rst_st_sop", bus_if.st_sop, 0);
        check("rst_st_eop", bus_if.st_eop, 0);
        check("rst_st_error", bus_if.st_error, 0);
        check("rst_st_data", bus_if.st_data, 0);
        check("rst_pkt_done", pkt_done, 0);
        check("rst_ovf_err", ovf_err, 0);
        check("rst_state", rd_state_dbg, IDLE);
        @(posedge clk_bus);
        #1 rst_n = 1'b1;
        @(negedge clk_bus);
        check("bus_ready_after_reset", bus_if.bus_ready, 1);
        @(posedge clk_bus);
        #1;

        // Table-driven single-packet runs.
        for (int v = 0; v < 4; v++) begin
            ready_mode = vecs[v].rmode;
            b0 = beats_seen;
            d0 = done_seen;
            send_pkt(vecs[v].base);
            if (vecs[v].chk_lat) begin
                lat   = 0;
                found = 1'b0;
                for (int c = 0; c < 8 && !found; c++) begin
                    @(negedge clk_bus);
                    if (bus_if.st_valid) found = 1'b1;
                    else                 lat++;
                end
                check("latency_to_sop", lat, vecs[v].exp_lat);
                check("first_beat_sop", bus_if.st_sop, 1);
                @(posedge clk_bus);
                #1;
            end
            wait_drain(10000);
            check("vec_beats", beats_seen - b0, vecs[v].exp_beats);
            check("vec_pkt_done", done_seen - d0, vecs[v].exp_done);
            check("vec_ovf_err", ovf_err, vecs[v].exp_ovf);
            check("vec_bus_ready", bus_if.bus_ready, vecs[v].exp_ready);
        end

        // Ping-pong: 50 words back-to-back, packets separated by a 3-cycle gap.
        ready_mode = 0;
        b0 = beats_seen;
        d0 = done_seen;
        send_pkt(500);
        send_pkt(1500);
        @(negedge clk_bus);
        check("bus_ready_both_full", bus_if.bus_ready, 0);
        @(posedge clk_bus);
        #1;
        wait_drain(6000);
        check("pingpong_gap", last_gap, 3);
        check("pingpong_beats", beats_seen - b0, 2 * ST_PER_PKT);
        check("pingpong_done", done_seen - d0, 2);
        check("pingpong_bus_ready", bus_if.bus_ready, 1);

        // Overflow: sink stalled, 51st word dropped.
        ready_mode = 2;
        d0 = done_seen;
        send_pkt(2000);
        send_pkt(3000);
        bus_if.bus_data = make_word(3900, 0);
        bus_if.bus_en   = 1'b1;
        @(negedge clk_bus);
        check("bus_ready_at_ovf", bus_if.bus_ready, 0);
        @(posedge clk_bus);
        #1 bus_if.bus_en = 1'b0;
        @(negedge clk_bus);
        check("ovf_err_set", ovf_err, 1);
        check("bus_ready_after_ovf", bus_if.bus_ready, 0);
        check("no_done_while_stalled", done_seen - d0, 0);
        @(posedge clk_bus);
        #1 ready_mode = 1;
        wait_drain(12000);
        check("ovf_done", done_seen - d0, 2);
        check("ovf_err_sticky", ovf_err, 1);
        check("ovf_bus_ready_restored", bus_if.bus_ready, 1);

        // Reset at beat 500 of a streaming packet.
        ready_mode = 0;
        b0 = beats_seen;
        send_pkt(1234);
        n = 0;
        while ((beats_seen - b0) < 500 && n < 5000) begin
            @(negedge clk_bus);
            n++;
        end
        check("reached_beat_500", 32'((beats_seen - b0) >= 500), 1);
        @(posedge clk_bus);
        #1 rst_n = 1'b0;
        @(posedge clk_bus);
        @(negedge clk_bus);
        check("midrst_st_valid", bus_if.st_valid, 0);
        check("midrst_st_eop", bus_if.st_eop, 0);
        check("midrst_bus_ready", bus_if.bus_ready, 1);
        check("midrst_ovf_err", ovf_err, 0);
        check("midrst_state", rd_state_dbg, IDLE);
        @(posedge clk_bus);
        #1 rst_n = 1'b1;
        exp_q.delete();
        d0 = done_seen;
        b0 = beats_seen;
        send_pkt(77);
        wait_drain(6000);
        ready_mode = 1;
        send_pkt(1800);
        send_pkt(2900);
        wait_drain(12000);
        check("post_reset_beats", beats_seen - b0, 3 * ST_PER_PKT);
        check("post_reset_done", done_seen - d0, 3);
`ifdef BUS2ST_PKT_CNT_EN
        check("pkt_cnt_after_3", pkt_cnt, 3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard stop if something wedges beyond every bounded wait.
    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end
endmodule
